// File: rtl/ifetch_queue.sv
// Fetch stage: PC register, one-outstanding synchronous IROM read, and a decoupling
// {pc, inst} queue toward decode. Define IFQ_PERF_EN to add fetch/flush perf counters.
module ifetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              IADDR_W  = 14,
    parameter int              QDEPTH   = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        irom_req,
    output logic [IADDR_W-1:0]          inst_addr,
    input  logic [XLEN-1:0]             irom_inst,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_pc,
    output logic [XLEN-1:0]             out_pc4,
    output logic [XLEN-1:0]             out_inst,
`ifdef IFQ_PERF_EN
    output logic [31:0]                 perf_fetch,
    output logic [31:0]                 perf_flush,
`endif
    output logic [$clog2(QDEPTH):0]     q_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_f;
    logic            pending;
    logic [XLEN-1:0] pend_pc;
    logic [XLEN-1:0] mem_pc   [QDEPTH];
    logic [XLEN-1:0] mem_inst [QDEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW:0]     credit_used;
    logic            pop;
    logic            push;
    logic            issue;

    always_comb begin
        out_valid   = rst && !redirect && (count != '0);
        pop         = out_valid && out_ready;
        push        = rst && !redirect && pending;
        // Entries held plus the one in flight, less the one leaving this cycle, bound the queue.
        credit_used = {1'b0, count} + (CW+1)'(pending) - (CW+1)'(pop);
        issue       = rst && !redirect && (credit_used < (CW+1)'(QDEPTH));
        irom_req    = issue;
        inst_addr   = pc_f[IADDR_W+1:2];
        out_pc      = mem_pc[rd_ptr];
        out_inst    = mem_inst[rd_ptr];
        out_pc4     = out_pc + XLEN'(4);
        q_count     = count;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_f    <= RESET_PC;
            pending <= 1'b0;
            pend_pc <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else if (redirect) begin
            pc_f    <= {redirect_pc[XLEN-1:2], 2'b00};
            pending <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            pending <= issue;
            if (issue) begin
                pc_f    <= pc_f + XLEN'(4);
                pend_pc <= pc_f;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= pend_pc;
            mem_inst[wr_ptr] <= irom_inst;
        end
    end

`ifdef IFQ_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_fetch <= '0;
            perf_flush <= '0;
        end else begin
            if (issue) perf_fetch <= perf_fetch + 32'd1;
            if (redirect && (pending || (count != '0))) perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue; IROM model returns 0xC0DE0000 | word address.
module tb_ifetch_queue;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        irom_req;
    logic [13:0] inst_addr;
    logic [31:0] irom_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_inst;
    logic [2:0]  q_count;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;
`endif

    int vectors;
    int miscompares;

    ifetch_queue #(.XLEN(32), .IADDR_W(14), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .irom_req    (irom_req),
        .inst_addr   (inst_addr),
        .irom_inst   (irom_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4),
        .out_inst    (out_inst),
`ifdef IFQ_PERF_EN
        .perf_fetch  (perf_fetch),
        .perf_flush  (perf_flush),
`endif
        .q_count     (q_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (irom_req) irom_inst <= 32'hC0DE_0000 | 32'(inst_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        int          nreq;
        logic        seen;
        logic [13:0] first_addr;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;

        nxt(); nxt(); #1;
        chk("rst_qcount", 32'(q_count), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_req", 32'(irom_req), 0);

        // Streaming from reset: first pc visible in the third cycle.
        nxt(); rst = 1'b1; #1;
        chk("t1_req0", 32'(irom_req), 1);
        chk("t1_addr0", 32'(inst_addr), 0);
        chk("t1_valid0", 32'(out_valid), 0);
        nxt(); #1;
        chk("t1_valid1", 32'(out_valid), 0);
        chk("t1_addr1", 32'(inst_addr), 1);
        for (int k = 0; k < 6; k++) begin
            nxt(); #1;
            chk("t1_valid", 32'(out_valid), 1);
            chk("t1_pc", out_pc, 32'(4 * k));
            chk("t1_pc4", out_pc4, 32'(4 * k + 4));
            chk("t1_inst", out_inst, 32'hC0DE_0000 | 32'(k));
        end
        chk("t1_qcount", 32'(q_count), 1);

        // Build q_count=3 with a read pending, then redirect to 0x103.
        nxt(); out_ready = 1'b0;
        nxt();
        nxt(); redirect = 1'b1; redirect_pc = 32'h0000_0103; out_ready = 1'b1; #1;
        chk("t3_qcount_pre", 32'(q_count), 3);
        chk("t3_valid_redir", 32'(out_valid), 0);
        chk("t3_req_redir", 32'(irom_req), 0);
        nxt(); redirect = 1'b0; #1;
        chk("t3_qcount_post", 32'(q_count), 0);
        chk("t3_req", 32'(irom_req), 1);
        chk("t3_addr", 32'(inst_addr), 32'h40);
        chk("t3_valid_a", 32'(out_valid), 0);
        nxt(); #1;
        chk("t3_valid_b", 32'(out_valid), 0);
        nxt(); #1;
        chk("t3_valid_c", 32'(out_valid), 1);
        chk("t3_pc", out_pc, 32'h100);
        chk("t3_inst", out_inst, 32'hC0DE_0040);
        nxt(); #1;
        chk("t3_pc_next", out_pc, 32'h104);

        // Back-to-back redirects: last one wins.
        nxt(); redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk("t4_req_a", 32'(irom_req), 0);
        chk("t4_valid_a", 32'(out_valid), 0);
        nxt(); redirect_pc = 32'h300; #1;
        chk("t4_req_b", 32'(irom_req), 0);
        nxt(); redirect = 1'b0; #1;
        chk("t4_req", 32'(irom_req), 1);
        chk("t4_addr", 32'(inst_addr), 32'hC0);
        chk("t4_valid_c", 32'(out_valid), 0);
        nxt(); #1;
        chk("t4_valid_d", 32'(out_valid), 0);
        nxt(); #1;
        chk("t4_valid_e", 32'(out_valid), 1);
        chk("t4_pc", out_pc, 32'h300);

        // Reset mid-operation with q_count=2 and a read pending.
        nxt(); out_ready = 1'b0;
        nxt(); rst = 1'b0; #1;
        chk("t5_qcount_pre", 32'(q_count), 2);
        nxt(); #1;
        chk("t5_qcount", 32'(q_count), 0);
        chk("t5_valid", 32'(out_valid), 0);
        chk("t5_req", 32'(irom_req), 0);
        nxt(); rst = 1'b1; out_ready = 1'b1; #1;
        chk("t5_req_rel", 32'(irom_req), 1);
        chk("t5_addr_rel", 32'(inst_addr), 0);
        nxt(); nxt(); #1;
        chk("t5_valid_rel", 32'(out_valid), 1);
        chk("t5_pc_rel", out_pc, 0);

        // Backpressure from reset: exactly QDEPTH requests, then drain in order.
        nxt(); rst = 1'b0;
        nxt(); rst = 1'b1; out_ready = 1'b0;
        nreq = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (irom_req) nreq++;
            nxt();
        end
        #1;
        chk("t2_nreq", 32'(nreq), 4);
        chk("t2_qcount", 32'(q_count), 4);
        chk("t2_req_stalled", 32'(irom_req), 0);
        chk("t2_valid", 32'(out_valid), 1);
        out_ready = 1'b1; #1;
        seen = 1'b0;
        first_addr = '0;
        for (int k = 0; k < 5; k++) begin
            chk("t2_pc", out_pc, 32'(4 * k));
            if (irom_req && !seen) begin
                seen = 1'b1;
                first_addr = inst_addr;
            end
            nxt(); #1;
        end
        chk("t2_resumed", 32'(seen), 1);
        chk("t2_resume_addr", 32'(first_addr), 4);

`ifdef IFQ_PERF_EN
        nxt(); rst = 1'b0; out_ready = 1'b1; redirect = 1'b0;
        nxt(); #1;
        chk("t6_fetch_rst", perf_fetch, 0);
        chk("t6_flush_rst", perf_flush, 0);
        nxt(); rst = 1'b1;
        repeat (10) nxt();
        redirect = 1'b1; redirect_pc = 32'h400; #1;
        chk("t6_fetch10", perf_fetch, 10);
        nxt(); #1;
        chk("t6_flush1", perf_flush, 1);
        nxt(); redirect = 1'b0; #1;
        chk("t6_flush_idle", perf_flush, 1);
        chk("t6_fetch_hold", perf_fetch, 10);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
